// File: rtl/servo_seq_ctrl.sv
// Multi-channel servo sequencer: one PWM pulse per frame per channel,
// stepping through a loadable per-mode table of poses and dwell counts.
module servo_seq_ctrl #(
    parameter int NUM_SERVO = 3,
    parameter int NUM_MODES = 2,
    parameter int NUM_STEPS = 8,
    parameter int PERIOD    = 1000000,
    parameter int PW_W      = 21,
    parameter int DWELL_W   = 8,
    parameter logic [NUM_SERVO*PW_W-1:0] HOME_PW = {NUM_SERVO{21'd75000}},
    localparam int MW = $clog2(NUM_MODES),
    localparam int SW = $clog2(NUM_STEPS),
    localparam int CW = $clog2(NUM_SERVO + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MW-1:0]        mode,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [MW-1:0]        done_mode,
    output logic [SW-1:0]        step_idx,
    input  logic                 tbl_we,
    input  logic [MW-1:0]        tbl_mode,
    input  logic [SW-1:0]        tbl_step,
    input  logic [CW-1:0]        tbl_chan,
    input  logic [PW_W-1:0]      tbl_data,
    output logic [NUM_SERVO-1:0] pwm_out
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [PW_W-1:0] LAST = PW_W'(PERIOD - 1);

    state_t             state, state_nxt;
    logic [PW_W-1:0]    frame_cnt;
    logic [PW_W-1:0]    pw_cur [NUM_SERVO];
    logic [PW_W-1:0]    pw_tbl [NUM_MODES][NUM_STEPS][NUM_SERVO];
    logic [DWELL_W-1:0] dw_tbl [NUM_MODES][NUM_STEPS];
    logic [DWELL_W-1:0] remaining;
    logic [DWELL_W-1:0] dw0;
    logic [MW-1:0]      cur_mode;
    logic [SW-1:0]      nxt_step;
    logic               zd_done, home_pend;
    logic               fb, tick, wr_ok, start_ok, has_next;
    logic               arm_load, run_end, run_adv, run_fin, run_dec;

    always_comb begin
        fb       = (frame_cnt == LAST);
        tick     = fb && !abort;
        wr_ok    = tbl_we && (state == IDLE) && !busy;
        start_ok = start && !abort && (state == IDLE) && !busy;
        // A same-cycle dwell write must be visible to the start decision
        dw0 = dw_tbl[mode][0];
        if (wr_ok && tbl_mode == mode && tbl_step == '0 &&
            tbl_chan == CW'(NUM_SERVO))
            dw0 = tbl_data[DWELL_W-1:0];
        nxt_step = step_idx + 1'b1;
        has_next = (step_idx != SW'(NUM_STEPS - 1)) &&
                   (dw_tbl[cur_mode][nxt_step] != '0);
        arm_load = (state == ARM) && tick;
        run_end  = (state == RUN) && tick && (remaining == DWELL_W'(1));
        run_adv  = run_end && has_next;
        run_fin  = run_end && !has_next;
        run_dec  = (state == RUN) && tick && (remaining != DWELL_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok && dw0 != '0) state_nxt = ARM;
            ARM: begin
                if (abort)   state_nxt = IDLE;
                else if (fb) state_nxt = RUN;
            end
            RUN: if (abort || run_fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = zd_done || run_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            zd_done   <= 1'b0;
            done_mode <= '0;
            step_idx  <= '0;
            cur_mode  <= '0;
            remaining <= '0;
            home_pend <= 1'b0;
        end else begin
            zd_done <= start_ok && (dw0 == '0);
            if (start_ok)           busy <= 1'b1;
            else if (abort || done) busy <= 1'b0;
            if (start_ok && dw0 == '0) done_mode <= mode;
            else if (run_fin)          done_mode <= cur_mode;
            if (start_ok) begin
                step_idx <= '0;
                cur_mode <= mode;
            end else if (run_adv) begin
                step_idx <= nxt_step;
            end
            if (arm_load)     remaining <= dw_tbl[cur_mode][0];
            else if (run_adv) remaining <= dw_tbl[cur_mode][nxt_step];
            else if (run_dec) remaining <= remaining - 1'b1;
            // Homing waits for the frame boundary so no pulse is cut short
            if (fb)         home_pend <= 1'b0;
            else if (abort) home_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            pwm_out   <= '0;
            for (int c = 0; c < NUM_SERVO; c++)
                pw_cur[c] <= HOME_PW[c*PW_W +: PW_W];
        end else begin
            frame_cnt <= fb ? '0 : frame_cnt + 1'b1;
            for (int c = 0; c < NUM_SERVO; c++) begin
                pwm_out[c] <= (frame_cnt < pw_cur[c]);
                if (arm_load)
                    pw_cur[c] <= pw_tbl[cur_mode][0][c];
                else if (run_adv)
                    pw_cur[c] <= pw_tbl[cur_mode][nxt_step][c];
                else if (fb && (home_pend || abort))
                    pw_cur[c] <= HOME_PW[c*PW_W +: PW_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < NUM_MODES; m++)
                for (int s = 0; s < NUM_STEPS; s++) begin
                    dw_tbl[m][s] <= '0;
                    for (int c = 0; c < NUM_SERVO; c++)
                        pw_tbl[m][s][c] <= HOME_PW[c*PW_W +: PW_W];
                end
        end else if (wr_ok) begin
            if (tbl_chan < CW'(NUM_SERVO))
                pw_tbl[tbl_mode][tbl_step][tbl_chan] <= tbl_data;
            else if (tbl_chan == CW'(NUM_SERVO))
                dw_tbl[tbl_mode][tbl_step] <= tbl_data[DWELL_W-1:0];
        end
    end

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Bench for servo_seq_ctrl: frame-queue reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_servo_seq_ctrl;

    localparam int PERIOD = 100;
    localparam int HOME   = 75;

    typedef struct {
        int step;
        int w0, w1, w2;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [0:0]  mode = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [0:0]  done_mode;
    logic [2:0]  step_idx;
    logic        tbl_we = 1'b0;
    logic [0:0]  tbl_mode = '0;
    logic [2:0]  tbl_step = '0;
    logic [1:0]  tbl_chan = '0;
    logic [20:0] tbl_data = '0;
    logic [2:0]  pwm_out;

    servo_seq_ctrl #(
        .NUM_SERVO(3), .NUM_MODES(2), .NUM_STEPS(8),
        .PERIOD(PERIOD), .PW_W(21), .DWELL_W(8),
        .HOME_PW({3{21'd75}})
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .abort(abort), .busy(busy), .done(done),
        .done_mode(done_mode), .step_idx(step_idx),
        .tbl_we(tbl_we), .tbl_mode(tbl_mode), .tbl_step(tbl_step),
        .tbl_chan(tbl_chan), .tbl_data(tbl_data), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, last_done_cyc = 0;

    // Reference model: a start expands the table into a queue of frames;
    // every frame boundary pops one frame, an empty queue means done.
    int     m_cnt, m_step, m_mode, m_done_mode;
    int     m_pw [3];
    int     m_tw [2][8][3];
    int     m_dw [2][8];
    bit     m_busy, m_zd, m_active, m_pend;
    logic [2:0] m_pwm;
    frame_t q[$];

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     n, a, e, cyc);
        end
    endtask

    task m_reset();
        m_cnt = 0; m_step = 0; m_mode = 0; m_done_mode = 0;
        m_busy = 0; m_zd = 0; m_active = 0; m_pend = 0; m_pwm = '0;
        q.delete();
        for (int c = 0; c < 3; c++) m_pw[c] = HOME;
        for (int m = 0; m < 2; m++)
            for (int s = 0; s < 8; s++) begin
                m_dw[m][s] = 0;
                for (int c = 0; c < 3; c++) m_tw[m][s][c] = HOME;
            end
    endtask

    always @(negedge clk) begin
        bit fb, e_done, acc, nb, zd_n, stop;
        logic [2:0] npwm;
        frame_t f;
        cyc++;
        if (rst) begin
            chk("rst_pwm", int'(pwm_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_done_mode", int'(done_mode), 0);
            chk("rst_step", int'(step_idx), 0);
            m_reset();
        end else begin
            fb = (m_cnt == PERIOD - 1);
            e_done = m_zd || (m_active && fb && !abort && q.size() == 0);
            chk("pwm_out", int'(pwm_out), int'(m_pwm));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(e_done));
            chk("done_mode", int'(done_mode), m_done_mode);
            chk("step_idx", int'(step_idx), m_step);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (tbl_we && !m_busy) begin
                if (tbl_chan == 2'd3)
                    m_dw[tbl_mode][tbl_step] = int'(tbl_data[7:0]);
                else
                    m_tw[tbl_mode][tbl_step][tbl_chan] = int'(tbl_data);
            end
            for (int c = 0; c < 3; c++) npwm[c] = (m_cnt < m_pw[c]);
            acc = start && !abort && !m_busy;
            nb = m_busy;
            zd_n = 0;
            if (m_zd) nb = 0;
            if (abort) begin
                m_active = 0;
                q.delete();
                nb = 0;
            end
            if (fb) begin
                if (m_active && !abort) begin
                    if (q.size() > 0) begin
                        f = q.pop_front();
                        m_pw[0] = f.w0; m_pw[1] = f.w1; m_pw[2] = f.w2;
                        m_step = f.step;
                    end else begin
                        m_active = 0;
                        nb = 0;
                        m_done_mode = m_mode;
                    end
                end else if (m_pend || abort) begin
                    for (int c = 0; c < 3; c++) m_pw[c] = HOME;
                end
                m_pend = 0;
            end else if (abort) begin
                m_pend = 1;
            end
            if (acc) begin
                m_step = 0;
                nb = 1;
                if (m_dw[mode][0] == 0) begin
                    zd_n = 1;
                    m_done_mode = int'(mode);
                end else begin
                    m_active = 1;
                    m_mode = int'(mode);
                    stop = 0;
                    for (int s = 0; s < 8; s++) begin
                        if (m_dw[mode][s] == 0) stop = 1;
                        if (!stop)
                            for (int k = 0; k < m_dw[mode][s]; k++) begin
                                f.step = s;
                                f.w0 = m_tw[mode][s][0];
                                f.w1 = m_tw[mode][s][1];
                                f.w2 = m_tw[mode][s][2];
                                q.push_back(f);
                            end
                    end
                end
            end
            m_zd = zd_n;
            m_busy = nb;
            m_pwm = npwm;
            m_cnt = fb ? 0 : m_cnt + 1;
        end
    end

    task nxt();
        @(posedge clk);
        #1;
        start = 0; abort = 0; tbl_we = 0;
    endtask

    task wr(input int m, input int s, input int ch, input int d);
        tbl_we = 1;
        tbl_mode = 1'(m);
        tbl_step = 3'(s);
        tbl_chan = 2'(ch);
        tbl_data = 21'(d);
        nxt();
    endtask

    task wait_cnt(input int v);
        int k = 0;
        while (m_cnt != v && k < 300) begin
            nxt();
            k++;
        end
        chk("wait_cnt_timeout", int'(m_cnt == v), 1);
    endtask

    task wait_done(input string n, input int lim);
        int d = done_cnt;
        int k = 0;
        while (done_cnt == d && k < lim) begin
            nxt();
            k++;
        end
        chk(n, int'(done_cnt != d), 1);
    endtask

    // High time per channel over one frame of the registered output
    task measure(output int h0, output int h1, output int h2);
        wait_cnt(1);
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            nxt();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, sc, d0, k;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("lit_rst_pwm", int'(pwm_out), 0);
        nxt();
        rst = 0;
        nxt();

        measure(h0, h1, h2);
        chk("lit_home_ch0", h0, 75);
        chk("lit_home_ch1", h1, 75);
        chk("lit_home_ch2", h2, 75);
        chk("lit_no_done_idle", done_cnt, 0);

        wr(0, 0, 0, 80); wr(0, 0, 1, 75); wr(0, 0, 2, 72); wr(0, 0, 3, 2);
        wr(0, 1, 0, 80); wr(0, 1, 1, 75); wr(0, 1, 2, 96); wr(0, 1, 3, 3);

        // Start at count 50; a start and a shortening write while busy
        // must both be ignored
        wait_cnt(50);
        start = 1; mode = 0;
        sc = cyc + 1;
        nxt();
        repeat (10) nxt();
        start = 1; mode = 1;
        tbl_we = 1; tbl_mode = 0; tbl_step = 1; tbl_chan = 3; tbl_data = 1;
        nxt();
        wait_done("seq0_done_timeout", 1000);
        chk("lit_seq0_latency", last_done_cyc - sc, 549);
        chk("lit_seq0_done_mode", int'(done_mode), 0);
        chk("lit_seq0_step", int'(step_idx), 1);
        measure(h0, h1, h2);
        chk("lit_pose_ch0", h0, 80);
        chk("lit_pose_ch2", h2, 96);

        start = 1; mode = 1;
        nxt();
        @(negedge clk);
        chk("lit_zd_done", int'(done), 1);
        chk("lit_zd_busy", int'(busy), 1);
        nxt();
        @(negedge clk);
        chk("lit_zd_busy_after", int'(busy), 0);
        chk("lit_zd_done_mode", int'(done_mode), 1);
        nxt();

        start = 1; mode = 0;
        nxt();
        k = 0;
        while (!(m_step == 1 && m_busy) && k < 1000) begin
            nxt();
            k++;
        end
        chk("step1_timeout", int'(m_step == 1), 1);
        d0 = done_cnt;
        wait_cnt(1);
        h2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 30) abort = 1;
            @(negedge clk);
            h2 += int'(pwm_out[2]);
            if (i == 31) chk("lit_abort_busy", int'(busy), 0);
            nxt();
        end
        chk("lit_abort_no_trunc", h2, 96);
        measure(h0, h1, h2);
        chk("lit_abort_home_ch2", h2, 75);
        chk("lit_abort_home_ch0", h0, 75);
        chk("lit_abort_no_done", done_cnt, d0);

        wr(1, 0, 0, 0); wr(1, 0, 1, 150); wr(1, 0, 2, 75); wr(1, 0, 3, 1);
        start = 1; mode = 1;
        nxt();
        wait_done("seq1_done_timeout", 500);
        measure(h0, h1, h2);
        chk("lit_width0_low", h0, 0);
        chk("lit_width150_high", h1, 100);

        wait_cnt(20);
        rst = 1;
        @(negedge clk);
        chk("lit_rst_mid_pwm", int'(pwm_out), 0);
        nxt();
        nxt();
        rst = 0;
        nxt();
        start = 1; mode = 1;
        nxt();
        @(negedge clk);
        chk("lit_rst_tbl_cleared", int'(done), 1);
        nxt();

        for (int i = 0; i < 20000; i++) begin
            start = ($urandom_range(0, 99) == 0);
            mode = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 799) == 0);
            tbl_we = ($urandom_range(0, 3) == 0);
            tbl_mode = 1'($urandom_range(0, 1));
            tbl_step = 3'($urandom_range(0, 7));
            tbl_chan = 2'($urandom_range(0, 3));
            if (tbl_chan == 2'd3)
                tbl_data = {13'($urandom_range(0, 8191)),
                            8'(($urandom_range(0, 4) == 0) ? 0 :
                               $urandom_range(1, 3))};
            else
                tbl_data = 21'($urandom_range(0, 110));
            @(posedge clk);
            #1;
        end
        start = 0; abort = 0; tbl_we = 0;
        nxt();
        chk("lit_random_done_seen", int'(done_cnt > 3), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
